// File: rtl/trap_pkg.sv
// Shared trap-sequencer definitions: FSM states, machine CSR addresses and cause codes.
package trap_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EPC,
    ST_CAUSE,
    ST_STATUS,
    ST_RESTORE,
    ST_JUMP
  } state_e;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_AW-1:0] CSR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [XLEN-1:0] CAUSE_EXT_IRQ = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_TMR_IRQ = 32'h8000_0007;

  // mstatus image with MPP fixed to machine mode; all other fields zero.
  function automatic logic [XLEN-1:0] mstatus_word(input logic mie, input logic mpie);
    return {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for an asynchronous active-low interrupt line; flops reset inactive.
module irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_async;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/trap_seq.sv
// Machine-mode trap/MRET sequencer: serialises mepc/mcause/mstatus writes, then redirects the PC.
module trap_seq
  import trap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ei,
  input  logic              ti,
  input  logic              ecall_n,
  input  logic              ebreak_n,
  input  logic              mret_n,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   mstatus,
  input  logic [XLEN-1:0]   mie,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              stall,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc
);

  state_e              r_state;
  logic [XLEN-1:0]     r_cause;
  logic                r_mpie;
  logic                r_stall;
  logic                r_csr_we;
  logic [CSR_AW-1:0]   r_csr_waddr;
  logic [XLEN-1:0]     r_csr_wdata;
  logic                r_redirect;
  logic [XLEN-1:0]     r_redirect_pc;

  logic                w_ei_n;
  logic                w_ti_n;
  logic                w_ext_irq;
  logic                w_tmr_irq;
  logic                w_trap_cond;
  logic                w_take_trap;
  logic                w_take_mret;
  logic [XLEN-1:0]     w_cause;
  logic [XLEN-1:0]     w_trap_base;
  logic [XLEN-1:0]     w_trap_tgt;

  irq_sync #(.STAGES(SYNC_STAGES)) u_ei_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ei),
    .o_sync  (w_ei_n)
  );

  irq_sync #(.STAGES(SYNC_STAGES)) u_ti_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ti),
    .o_sync  (w_ti_n)
  );

  assign w_ext_irq   = ~w_ei_n & mstatus[3] & mie[11];
  assign w_tmr_irq   = ~w_ti_n & mstatus[3] & mie[7];
  assign w_trap_cond = ~ecall_n | ~ebreak_n | w_ext_irq | w_tmr_irq;
  assign w_take_trap = (r_state == ST_IDLE) & instr_valid & w_trap_cond;
  assign w_take_mret = (r_state == ST_IDLE) & instr_valid & ~mret_n & ~w_trap_cond;

  // Fixed priority: ecall > ebreak > external > timer.
  always_comb begin
    w_cause = CAUSE_TMR_IRQ;
    if (!ecall_n)       w_cause = CAUSE_ECALL;
    else if (!ebreak_n) w_cause = CAUSE_EBREAK;
    else if (w_ext_irq) w_cause = CAUSE_EXT_IRQ;
  end

  // Vectored targets apply only to interrupts; the add wraps at 32 bits.
  assign w_trap_base = {mtvec[XLEN-1:2], 2'b00};
  assign w_trap_tgt  = (VECTORED_EN && (mtvec[1:0] == 2'b01) && r_cause[XLEN-1])
                     ? w_trap_base + {25'd0, r_cause[4:0], 2'b00}
                     : w_trap_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cause       <= '0;
      r_mpie        <= 1'b0;
      r_stall       <= 1'b0;
      r_csr_we      <= 1'b0;
      r_csr_waddr   <= '0;
      r_csr_wdata   <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_csr_we      <= 1'b0;
      r_csr_waddr   <= '0;
      r_csr_wdata   <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_take_trap) begin
            r_state     <= ST_EPC;
            r_cause     <= w_cause;
            r_mpie      <= mstatus[3];
            r_stall     <= 1'b1;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MEPC;
            r_csr_wdata <= {pc[XLEN-1:2], 2'b00};
          end else if (w_take_mret) begin
            r_state     <= ST_RESTORE;
            r_stall     <= 1'b1;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MSTATUS;
            r_csr_wdata <= mstatus_word(mstatus[7], 1'b1);
          end
        end
        ST_EPC: begin
          r_state     <= ST_CAUSE;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MCAUSE;
          r_csr_wdata <= r_cause;
        end
        ST_CAUSE: begin
          r_state     <= ST_STATUS;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MSTATUS;
          r_csr_wdata <= mstatus_word(1'b0, r_mpie);
        end
        ST_STATUS: begin
          r_state       <= ST_JUMP;
          r_redirect    <= 1'b1;
          r_redirect_pc <= w_trap_tgt;
        end
        ST_RESTORE: begin
          r_state       <= ST_JUMP;
          r_redirect    <= 1'b1;
          r_redirect_pc <= {mepc[XLEN-1:2], 2'b00};
        end
        ST_JUMP: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs land one cycle after each state transition; stall also covers the trap cycle.
  assign csr_we      = r_csr_we;
  assign csr_waddr   = r_csr_waddr;
  assign csr_wdata   = r_csr_wdata;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign stall       = rst_n & (r_stall | w_take_trap | w_take_mret);

  logic w_unused;
  assign w_unused = &{1'b0, mstatus[31:8], mstatus[6:4], mstatus[2:0], mie[31:12],
                      mie[10:8], mie[6:0], pc[1:0], mepc[1:0]};

endmodule

// File: tb/tb_trap_seq.sv
// Scoreboard bench for trap_seq: per-cycle expected outputs are queued with stimulus and checked at negedge.
module tb_trap_seq;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ei, ti, ecall_n, ebreak_n, mret_n, instr_valid;
  logic [31:0] pc, mstatus, mie, mtvec, mepc;
  logic        csr_we, stall, redirect;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  obs_t obs;
  obs_t exp_v;
  obs_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  trap_seq #(.SYNC_STAGES(2), .VECTORED_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ei          (ei),
    .ti          (ti),
    .ecall_n     (ecall_n),
    .ebreak_n    (ebreak_n),
    .mret_n      (mret_n),
    .instr_valid (instr_valid),
    .pc          (pc),
    .mstatus     (mstatus),
    .mie         (mie),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .csr_we      (csr_we),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  assign obs = {stall, redirect, redirect_pc, csr_we, csr_waddr, csr_wdata};

  function automatic obs_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic we, input logic [11:0] a, input logic [31:0] d);
    return {s, r, rpc, we, a, d};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("stall=%b redir=%b rpc=%h we=%b addr=%h data=%h",
                     o.stall, o.redir, o.rpc, o.we, o.addr, o.data);
  endfunction

  // Expected cycle-by-cycle trace of one trap: take, mepc, mcause, mstatus, redirect, [idle].
  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] st, input logic [31:0] tgt, input bit tail_idle);
    q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 12'h341, epc));
    q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 12'h342, cause));
    q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 12'h300, st));
    q.push_back(mk(1'b1, 1'b1, tgt,   1'b0, 12'h000, 32'h0));
    if (tail_idle) q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
  endtask

  task automatic idle_inputs();
    ei = 1'b1; ti = 1'b1; ecall_n = 1'b1; ebreak_n = 1'b1; mret_n = 1'b1;
    instr_valid = 1'b0; pc = '0; mstatus = '0; mie = '0; mtvec = '0; mepc = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    instr_valid = 1'b1;
    ecall_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      if (i == 2) begin
        rst_n = 1'b1;
        idle_inputs();
      end
    end
  endtask

  task automatic test_irq(input string name, input bit use_ei, input logic [31:0] mie_v,
                          input logic [31:0] mtvec_v, input logic [31:0] pc_v,
                          input logic [31:0] cause, input logic [31:0] tgt);
    idle_inputs();
    mstatus = 32'h8;
    mie = mie_v;
    mtvec = mtvec_v;
    if (use_ei) ei = 1'b0;
    else ti = 1'b0;
    wait_cycles(3);
    pc = pc_v;
    instr_valid = 1'b1;
    push_trap({pc_v[31:2], 2'b00}, cause, 32'h1880, tgt, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL %s cyc%0d: got %s expected %s", name, i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
    idle_inputs();
    wait_cycles(3);
  endtask

  task automatic test_ecall_over_mret();
    idle_inputs();
    ecall_n = 1'b0;
    mret_n = 1'b0;
    mtvec = 32'h201;
    mepc = 32'h800;
    pc = 32'h300;
    instr_valid = 1'b1;
    push_trap(32'h300, 32'hB, 32'h1800, 32'h200, 1'b1);
    q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL ecall_mret cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_mret();
    idle_inputs();
    mret_n = 1'b0;
    mstatus = 32'h80;
    mepc = 32'h403;
    instr_valid = 1'b1;
    q.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 12'h000, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 32'h0,   1'b1, 12'h300, 32'h1888));
    q.push_back(mk(1'b1, 1'b1, 32'h400, 1'b0, 12'h000, 32'h0));
    q.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 12'h000, 32'h0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL mret cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_masked_irq();
    idle_inputs();
    ei = 1'b0;
    ti = 1'b0;
    mstatus = 32'h0;
    mie = 32'h880;
    mtvec = 32'h200;
    wait_cycles(3);
    instr_valid = 1'b1;
    pc = 32'h120;
    for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL masked_irq cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    wait_cycles(3);
  endtask

  task automatic test_priority();
    idle_inputs();
    ebreak_n = 1'b0;
    ei = 1'b0;
    mstatus = 32'h8;
    mie = 32'h800;
    mtvec = 32'h201;
    wait_cycles(3);
    pc = 32'h1234;
    instr_valid = 1'b1;
    push_trap(32'h1234, 32'h3, 32'h1880, 32'h200, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL priority cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
    idle_inputs();
    wait_cycles(3);
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    ecall_n = 1'b0;
    mtvec = 32'h200;
    pc = 32'h600;
    instr_valid = 1'b1;
    push_trap(32'h600, 32'hB, 32'h1800, 32'h200, 1'b0);
    push_trap(32'h600, 32'hB, 32'h1800, 32'h200, 1'b1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      if (i == 5) begin
        instr_valid = 1'b0;
        ecall_n = 1'b1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    ecall_n = 1'b0;
    mtvec = 32'h200;
    pc = 32'h500;
    instr_valid = 1'b1;
    q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 12'h341, 32'h500));
    q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 12'h342, 32'hB));
    q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d: got %s expected %s", i, fmt(obs), fmt(exp_v));
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      ecall_n = 1'b1;
      if (i == 1) rst_n = 1'b0;
      if (i == 2) rst_n = 1'b1;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_irq("ext_irq", 1'b1, 32'h800, 32'h200, 32'h100, 32'h8000000B, 32'h200);
    test_irq("tmr_vectored", 1'b0, 32'h80, 32'h201, 32'h103, 32'h80000007, 32'h21C);
    test_irq("tmr_wrap", 1'b0, 32'h80, 32'hFFFFFFF1, 32'h40, 32'h80000007, 32'h0000000C);
    test_irq("ext_over_tmr", 1'b1, 32'h880, 32'h201, 32'h44, 32'h8000000B, 32'h22C);
    test_ecall_over_mret();
    test_mret();
    test_masked_irq();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
